// File: rtl/q_value_update.sv
// q_value_update: fixed-point Q-learning update of this node's Q value after the best-neighbour search.
// Optional hop-count write-back enabled by defining QUPD_HOPWRITE_EN.
module q_value_update #(
  parameter logic [10:0] Q_ADDR       = 11'h010,
  parameter logic [10:0] E_ADDR       = 11'h011,
  parameter int          ALPHA_SHIFT  = 1,
  parameter int          GAMMA_SHIFT  = 2,
  parameter int          ENERGY_SHIFT = 4,
  parameter int          HOP_SHIFT    = 3
`ifdef QUPD_HOPWRITE_EN
  , parameter logic [10:0] H_ADDR     = 11'h012
`endif
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] bestQValue,
  input  logic [15:0] besthop,
  input  logic [15:0] data_in,
  output logic [10:0] address,
  output logic [15:0] data_out,
  output logic        wr_en,
  output logic [15:0] newQ,
  output logic        done
);
  typedef enum logic [3:0] {
    S_IDLE, S_RD_Q, S_RD_E, S_LAT_E, S_CALC_R, S_CALC_Q, S_WRITE, S_WRITE_H, S_DONE
  } state_t;
  state_t state, next_state;
  logic [15:0] best_q, best_hop, cur_q, energy, target;
  logic [19:0] e_scaled, h_pen;
  logic [17:0] reward, sum;
  logic [15:0] target_c, q_c, hop_inc;
  logic signed [17:0] diff, q_s;
  // Reward, discounted target, and the alpha-weighted step toward it; widened so nothing wraps before clamping.
  always_comb begin
    e_scaled = 20'(energy) >> ENERGY_SHIFT;
    h_pen    = 20'(best_hop) << HOP_SHIFT;
    reward   = (e_scaled > h_pen) ? 18'(e_scaled - h_pen) : 18'h0;
    sum      = reward + 18'(best_q) - 18'(best_q >> GAMMA_SHIFT);
    target_c = (sum > 18'h0FFFF) ? 16'hFFFF : sum[15:0];
    diff     = $signed({2'b00, target}) - $signed({2'b00, cur_q});
    q_s      = $signed({2'b00, cur_q}) + (diff >>> ALPHA_SHIFT);
    q_c      = (q_s < 0) ? 16'h0 : (q_s > 18'sh0FFFF) ? 16'hFFFF : q_s[15:0];
    hop_inc  = (best_hop == 16'hFFFF) ? best_hop : best_hop + 16'd1;
  end
  // State register; a low enable freezes the sequence where it is.
  always_ff @(posedge clock) begin
    if (!nrst) state <= S_IDLE;
    else if (en) state <= next_state;
  end
  // Fixed-length read/compute/write sequence; start is only heard in idle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    next_state = start ? S_RD_Q : S_IDLE;
      S_RD_Q:    next_state = S_RD_E;
      S_RD_E:    next_state = S_LAT_E;
      S_LAT_E:   next_state = S_CALC_R;
      S_CALC_R:  next_state = S_CALC_Q;
      S_CALC_Q:  next_state = S_WRITE;
`ifdef QUPD_HOPWRITE_EN
      S_WRITE:   next_state = S_WRITE_H;
`else
      S_WRITE:   next_state = S_DONE;
`endif
      S_WRITE_H: next_state = S_DONE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end
  // Operand capture, memory address sequencing and result register; address is set one cycle ahead of use.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      best_q   <= '0;
      best_hop <= '0;
      cur_q    <= '0;
      energy   <= '0;
      target   <= '0;
      address  <= '0;
      newQ     <= '0;
    end else if (en) begin
      if (state == S_IDLE && start) begin
        best_q   <= bestQValue;
        best_hop <= besthop;
        address  <= Q_ADDR;
      end
      if (state == S_RD_Q) address <= E_ADDR;
      if (state == S_RD_E) cur_q <= data_in;
      if (state == S_LAT_E) energy <= data_in;
      if (state == S_CALC_R) target <= target_c;
      if (state == S_CALC_Q) begin
        newQ    <= q_c;
        address <= Q_ADDR;
      end
`ifdef QUPD_HOPWRITE_EN
      if (state == S_WRITE) address <= H_ADDR;
`endif
    end
  end
  // Strobes are suppressed while stalled or in reset so a held write/done is issued exactly once.
  always_comb begin
    wr_en    = nrst && en && (state == S_WRITE || state == S_WRITE_H);
    done     = nrst && en && (state == S_DONE);
    data_out = !wr_en ? 16'h0 : (state == S_WRITE) ? newQ : hop_inc;
  end
endmodule

// File: tb/tb_q_value_update.sv
// tb_q_value_update: directed and random checks of q_value_update against an arithmetic reference model.
module tb_q_value_update;
`ifdef QUPD_HOPWRITE_EN
  localparam int NW = 2;
  localparam int DK = 8;
`else
  localparam int NW = 1;
  localparam int DK = 7;
`endif
  localparam logic [10:0] QA = 11'h010;
  localparam logic [10:0] EA = 11'h011;
  logic clock, nrst, en, start, wr_en, done;
  logic [15:0] bestQValue, besthop, data_in, data_out, newQ;
  logic [10:0] address;
  logic [15:0] mem [0:2047];
  logic tb_we;
  logic [10:0] tb_wa;
  logic [15:0] tb_wd;
  int vecs = 0, errs = 0;
  int nwr, ndone, done_k;
  int wr_k [0:3];
  logic [10:0] wr_a [0:3];
  logic [15:0] wr_d [0:3];
  logic [10:0] a1, a2;
  logic [59:0] rst_snap;

  q_value_update dut (
    .clock(clock), .nrst(nrst), .en(en), .start(start),
    .bestQValue(bestQValue), .besthop(besthop), .data_in(data_in),
    .address(address), .data_out(data_out), .wr_en(wr_en),
    .newQ(newQ), .done(done)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    data_in <= mem[address];
    if (wr_en) mem[address] <= data_out;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  function automatic int model_q(int cq, int e, int bq, int bh);
    int r, t, d, h, q;
    r = e / 16 - bh * 8;
    if (r < 0) r = 0;
    t = r + bq - bq / 4;
    if (t > 65535) t = 65535;
    d = t - cq;
    h = (d >= 0) ? d / 2 : -((1 - d) / 2);
    q = cq + h;
    if (q < 0) q = 0;
    if (q > 65535) q = 65535;
    return q;
  endfunction

  function automatic int sat_inc(int bh);
    return (bh >= 65535) ? 65535 : bh + 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] q, input logic [15:0] e);
    @(negedge clock);
    tb_we = 1; tb_wa = QA; tb_wd = q;
    @(negedge clock);
    tb_wa = EA; tb_wd = e;
    @(negedge clock);
    tb_we = 0;
  endtask

  task automatic run(input logic [15:0] bq, input logic [15:0] bh, input int stall_at, input int stall_len,
                     input int restart_at, input int rst_at);
    nwr = 0; ndone = 0; done_k = -1; rst_snap = '1;
    @(negedge clock);
    bestQValue = bq; besthop = bh; en = 1; start = 1;
    @(negedge clock);
    for (int k = 1; k <= 24; k++) begin
      en    = !(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
      start = (k == restart_at);
      nrst  = !(k == rst_at);
      #1;
      if (k == 1) a1 = address;
      if (k == 2) a2 = address;
      if (rst_at > 0 && k == rst_at + 1) rst_snap = {address, data_out, wr_en, newQ, done, 16'h0};
      if (wr_en) begin
        if (nwr < 4) begin
          wr_k[nwr] = k; wr_a[nwr] = address; wr_d[nwr] = data_out;
        end
        nwr++;
      end
      if (done) begin
        if (done_k < 0) done_k = k;
        ndone++;
      end
      @(negedge clock);
    end
    en = 1; start = 0; nrst = 1;
  endtask

  task automatic check_run(input string tag, input int exp_q, input int exp_h, input int shift);
    chk({tag, ".nwr"}, nwr, NW);
    chk({tag, ".rdq"}, a1, QA);
    chk({tag, ".rde"}, a2, EA);
    chk({tag, ".wk"}, wr_k[0], 6 + shift);
    chk({tag, ".wa"}, wr_a[0], QA);
    chk({tag, ".wd"}, wr_d[0], exp_q);
`ifdef QUPD_HOPWRITE_EN
    chk({tag, ".hk"}, wr_k[1], 7 + shift);
    chk({tag, ".ha"}, wr_a[1], 11'h012);
    chk({tag, ".hd"}, wr_d[1], exp_h);
`endif
    chk({tag, ".donek"}, done_k, DK + shift);
    chk({tag, ".ndone"}, ndone, 1);
    chk({tag, ".newQ"}, newQ, exp_q);
    chk({tag, ".mem"}, mem[QA], exp_q);
  endtask

  initial begin
    int q, e, bq, bh, x;
    tb_we = 0; tb_wa = '0; tb_wd = '0;
    nrst = 0; en = 1; start = 0; bestQValue = 0; besthop = 0;
    repeat (3) @(negedge clock);
    chk("rst.address", address, 0);
    chk("rst.data_out", data_out, 0);
    chk("rst.wr_en", wr_en, 0);
    chk("rst.newQ", newQ, 0);
    chk("rst.done", done, 0);
    nrst = 1;

    preload(16'h0100, 16'h1000);
    run(16'h0200, 16'd2, 0, 0, 0, 0);
    check_run("nominal", 16'h01B8, 3, 0);

    preload(16'h0100, 16'h0010);
    run(16'h0000, 16'd3, 0, 0, 0, 0);
    check_run("floor", 16'h0080, 4, 0);

    preload(16'h0100, 16'h1000);
    run(16'h0200, 16'd2, 4, 3, 0, 0);
    check_run("stall", 16'h01B8, 3, 3);

    preload(16'h0100, 16'h1000);
    run(16'h0200, 16'd2, 0, 0, 3, 0);
    check_run("busy", 16'h01B8, 3, 0);

    preload(16'h0100, 16'h1000);
    run(16'h0200, 16'd2, 0, 0, 0, 5);
    chk("reset.nwr", nwr, 0);
    chk("reset.ndone", ndone, 0);
    chk("reset.outs", rst_snap, 0);
    chk("reset.mem", mem[QA], 16'h0100);
    run(16'h0200, 16'd2, 0, 0, 0, 0);
    check_run("after_reset", 16'h01B8, 3, 0);

    preload(16'h0100, 16'h1000);
    run(16'h0200, 16'd2, 0, 0, DK + 1, 0);
    x = model_q(16'h01B8, 16'h1000, 16'h0200, 2);
    chk("b2b.nwr", nwr, 2 * NW);
    chk("b2b.wd0", wr_d[0], 16'h01B8);
    chk("b2b.wk1", wr_k[NW], DK + 7);
    chk("b2b.wd1", wr_d[NW], x);
    chk("b2b.ndone", ndone, 2);
    chk("b2b.newQ", newQ, x);

    for (int i = 0; i < 10; i++) begin
      q  = $urandom_range(0, 65535);
      e  = $urandom_range(0, 65535);
      bq = $urandom_range(0, 65535);
      bh = ($urandom_range(0, 4) == 0) ? 65535 : $urandom_range(0, 600);
      preload(16'(q), 16'(e));
      run(16'(bq), 16'(bh), 0, 0, 0, 0);
      check_run($sformatf("rand%0d", i), model_q(q, e, bq, bh), sat_inc(bh), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
